// File: rtl/seven_seg_scan_mux.sv
// Four-digit multiplexed common-anode seven-segment driver: per-slot anti-ghost
// blanking, frame-synchronous data update and optional leading-zero suppression.
module seven_seg_scan_mux #(
  parameter int CLKS_PER_DIGIT = 12500,
  parameter int BLANK_CLKS     = 250
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Load,
  input  logic [15:0] i_Digits,
  input  logic [3:0]  i_DP,
  input  logic        i_Blank_Lz,
  output logic [6:0]  o_Segment,
  output logic        o_DP,
  output logic [3:0]  o_DIG,
  output logic        o_Frame_Done,
  output logic [2:0]  o_Dbg_State
);

  localparam int CW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CLKS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [15:0]   pend_dig_q, pend_dig_d;
  logic [3:0]    pend_dp_q, pend_dp_d;
  logic          pend_vld_q, pend_vld_d;
  logic [15:0]   disp_dig_q, disp_dig_d;
  logic [3:0]    disp_dp_q, disp_dp_d;

  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    dig_q, dig_d;
  logic          fd_q, fd_d;

  logic          slot_last;
  logic          wrap;
  logic [3:0]    nib [4];
  logic [3:0]    zero_hi;
  logic [3:0]    cur_nib;
  logic          suppress;

  // Active-low segment pattern, bit6..bit0 = G..A; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Slot timing: each slot is BLANK for the first BLANK_CLKS counts, then DRIVE.
  always_comb begin
    slot_last = (cnt_q == CNT_LAST);
    wrap      = slot_last && (idx_q == 2'd3);
    cnt_d     = slot_last ? '0 : cnt_q + CW'(1);
    idx_d     = slot_last ? idx_q + 2'd1 : idx_q;
    state_d   = state_q;
    case (state_q)
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_DRIVE;
      ST_DRIVE: if (slot_last) state_d = ST_BLANK;
    endcase
  end

  // i_Load is a bare one-cycle strobe (no ready): it always overwrites the
  // pending copy; the display copy only changes on the wrap edge, so a load on
  // the wrap edge itself stays pending until the following wrap.
  always_comb begin
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    disp_dig_d = disp_dig_q;
    disp_dp_d  = disp_dp_q;
    if (i_Load) begin
      pend_dig_d = i_Digits;
      pend_dp_d  = i_DP;
      pend_vld_d = 1'b1;
    end else if (wrap) begin
      pend_vld_d = 1'b0;
    end
    if (wrap && pend_vld_q) begin
      disp_dig_d = pend_dig_q;
      disp_dp_d  = pend_dp_q;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      nib[k] = disp_dig_q[4*k +: 4];
    end
    zero_hi[3] = (nib[3] == 4'd0);
    zero_hi[2] = zero_hi[3] && (nib[2] == 4'd0);
    zero_hi[1] = zero_hi[2] && (nib[1] == 4'd0);
    zero_hi[0] = 1'b0;
    cur_nib    = nib[idx_q];
    suppress   = i_Blank_Lz && zero_hi[idx_q];

    dig_d = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (state_q == ST_DRIVE) begin
      dig_d = ~(4'b0001 << idx_q);
      seg_d = suppress ? 7'b1111111 : decode(cur_nib);
      dp_d  = ~disp_dp_q[idx_q];
    end
    fd_d = wrap;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= ST_BLANK;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      pend_dig_q <= 16'h0000;
      pend_dp_q  <= 4'h0;
      pend_vld_q <= 1'b0;
      disp_dig_q <= 16'h0000;
      disp_dp_q  <= 4'h0;
      seg_q      <= 7'b1111111;
      dp_q       <= 1'b1;
      dig_q      <= 4'b1111;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      disp_dig_q <= disp_dig_d;
      disp_dp_q  <= disp_dp_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
      fd_q       <= fd_d;
    end
  end

  assign o_Segment    = seg_q;
  assign o_DP         = dp_q;
  assign o_DIG        = dig_q;
  assign o_Frame_Done = fd_q;
  assign o_Dbg_State  = {idx_q, state_q == ST_DRIVE};

endmodule
